twiddle_cmult: RTL and testbench



---
 rtl/fft_pkg.sv | 29 ++
 rtl/twiddle_cmult_core.sv | 49 ++++
 rtl/twiddle_cmult.sv | 80 ++++++++
 tb/tb_twiddle_cmult.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath helpers: width math, complex field positions and the
// round-half-up / saturate step used when rescaling fixed-point products.
package fft_pkg;

  // Complex words are packed {re, im}: re occupies the upper half.
  localparam int CPX_RE = 1;
  localparam int CPX_IM = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Add half an LSB, arithmetic shift by frac, then clamp to a signed obits range.
  // Callers sign-extend into 64 bits, so x must be at most 64 bits wide.
  function automatic logic signed [63:0] rnd_sat(input logic signed [63:0] x,
                                                 input int frac, input int obits);
    logic signed [63:0] r, mx, mn;
    r  = (x + (64'sd1 <<< (frac - 1))) >>> frac;
    mx = (64'sd1 <<< (obits - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (obits - 1));
    if (r > mx) return mx;
    if (r < mn) return mn;
    return r;
  endfunction

endpackage

// File: rtl/twiddle_cmult_core.sv
// Complex multiply arithmetic: S2 registers the four partial products, S3
// combines them, rounds and saturates. Both stages advance only on i_en.
module cmult_core
  import fft_pkg::*;
#(
  parameter int DBITS = 16,
  parameter int CBITS = 16,
  parameter int CFRAC = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [DBITS-1:0] i_dr,
  input  logic [DBITS-1:0] i_di,
  input  logic [CBITS-1:0] i_cr,
  input  logic [CBITS-1:0] i_ci,
  output logic [DBITS-1:0] o_re,
  output logic [DBITS-1:0] o_im
);

  localparam int PW = DBITS + CBITS;
  localparam int SW = PW + 1;

  logic signed [PW-1:0] r_prr, r_pii, r_pri, r_pir;
  logic signed [SW-1:0] w_re_full, w_im_full;

  // One extra bit so (-max)*(-max) sums cannot wrap before saturation.
  assign w_re_full = SW'(r_prr) - SW'(r_pii);
  assign w_im_full = SW'(r_pri) + SW'(r_pir);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prr <= '0;
      r_pii <= '0;
      r_pri <= '0;
      r_pir <= '0;
      o_re  <= '0;
      o_im  <= '0;
    end else if (i_en) begin
      r_prr <= PW'($signed(i_dr)) * PW'($signed(i_cr));
      r_pii <= PW'($signed(i_di)) * PW'($signed(i_ci));
      r_pri <= PW'($signed(i_dr)) * PW'($signed(i_ci));
      r_pir <= PW'($signed(i_di)) * PW'($signed(i_cr));
      o_re  <= DBITS'(rnd_sat(64'(w_re_full), CFRAC, DBITS));
      o_im  <= DBITS'(rnd_sat(64'(w_im_full), CFRAC, DBITS));
    end
  end

endmodule

// File: rtl/twiddle_cmult.sv
// Streaming twiddle multiplier: 3-stage valid/ready pipeline around cmult_core
// with an output-side frame counter that marks the last sample of each frame.
module twiddle_cmult
  import fft_pkg::*;
#(
  parameter int DBITS = 16,
  parameter int CBITS = 16,
  parameter int CFRAC = 14,
  parameter int N     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*DBITS-1:0] in_data,
  input  logic [2*CBITS-1:0] coeff_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*DBITS-1:0] out_data,
  output logic               out_last
);

  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

  logic [3:1]       r_vld_pipe;
  logic [DBITS-1:0] r_dr, r_di;
  logic [CBITS-1:0] r_cr, r_ci;
  logic [CW-1:0]    r_cnt;
  logic [DBITS-1:0] w_re, w_im;
  logic             w_adv;
  logic             w_xfer;

  // Whole pipeline moves as one; only a held output stalls it.
  assign w_adv     = !r_vld_pipe[3] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld_pipe[3];
  assign w_xfer    = out_valid & out_ready;
  assign out_last  = out_valid & (r_cnt == CW'(N - 1));
  assign out_data  = {w_re, w_im};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_dr       <= '0;
      r_di       <= '0;
      r_cr       <= '0;
      r_ci       <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[2:1], in_valid};
      r_dr       <= in_data[CPX_RE*DBITS +: DBITS];
      r_di       <= in_data[CPX_IM*DBITS +: DBITS];
      r_cr       <= coeff_in[CPX_RE*CBITS +: CBITS];
      r_ci       <= coeff_in[CPX_IM*CBITS +: CBITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (w_xfer)
      r_cnt <= (r_cnt == CW'(N - 1)) ? '0 : r_cnt + CW'(1);
  end

  cmult_core #(
    .DBITS(DBITS),
    .CBITS(CBITS),
    .CFRAC(CFRAC)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_adv),
    .i_dr (r_dr),
    .i_di (r_di),
    .i_cr (r_cr),
    .i_ci (r_ci),
    .o_re (w_re),
    .o_im (w_im)
  );

endmodule

// File: tb/tb_twiddle_cmult.sv
// Directed bench for twiddle_cmult: arithmetic vectors, latency, backpressure,
// frame marking and mid-frame reset.
module tb_twiddle_cmult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] coeff_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  int n_chk  = 0;
  int n_fail = 0;

  twiddle_cmult #(.DBITS(16), .CBITS(16), .CFRAC(14), .N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coeff_in  (coeff_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Push one sample into an empty pipe; report result, latency and whether
  // out_valid is still high one cycle after the output was taken.
  task automatic one(input int cr, input int ci, input int dr, input int di,
                     output logic signed [15:0] re, output logic signed [15:0] im,
                     output int lat, output logic v_after);
    coeff_in  = {16'(cr), 16'(ci)};
    in_data   = {16'(dr), 16'(di)};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick;
      lat++;
    end
    re = out_data[31:16];
    im = out_data[15:0];
    tick;
    v_after = out_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; coeff_in = '0;
    tick; tick;
    rst = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    n_chk++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_identity;
    logic signed [15:0] re, im; int lat; logic va;
    one(16384, 0, 1000, -2000, re, im, lat, va);
    n_chk++; if (re !== 16'sd1000) begin n_fail++; $display("FAIL ident_re got=%0d exp=1000", re); end
    n_chk++; if (im !== -16'sd2000) begin n_fail++; $display("FAIL ident_im got=%0d exp=-2000", im); end
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL ident_latency got=%0d exp=3", lat); end
    n_chk++; if (va !== 1'b0) begin n_fail++; $display("FAIL ident_pulse got=%b exp=0", va); end
  endtask

  task automatic test_rotation;
    logic signed [15:0] re, im; int lat; logic va;
    one(0, 16384, 1000, -2000, re, im, lat, va);
    n_chk++; if (re !== 16'sd2000 || im !== 16'sd1000) begin n_fail++; $display("FAIL rot_j got=(%0d,%0d) exp=(2000,1000)", re, im); end
    one(11585, -11585, 16384, 0, re, im, lat, va);
    n_chk++; if (re !== 16'sd11585 || im !== -16'sd11585) begin n_fail++; $display("FAIL rot_45 got=(%0d,%0d) exp=(11585,-11585)", re, im); end
  endtask

  task automatic test_rounding;
    logic signed [15:0] re, im; int lat; logic va;
    one(8192, 0, 3, -3, re, im, lat, va);
    n_chk++; if (re !== 16'sd2 || im !== -16'sd1) begin n_fail++; $display("FAIL round_3 got=(%0d,%0d) exp=(2,-1)", re, im); end
    one(8192, 0, 1, -1, re, im, lat, va);
    n_chk++; if (re !== 16'sd1 || im !== 16'sd0) begin n_fail++; $display("FAIL round_1 got=(%0d,%0d) exp=(1,0)", re, im); end
  endtask

  task automatic test_saturation;
    logic signed [15:0] re, im; int lat; logic va;
    one(16384, 16384, 32767, 32767, re, im, lat, va);
    n_chk++; if (re !== 16'sd0 || im !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos got=(%0d,%0d) exp=(0,32767)", re, im); end
    one(16384, 16384, -32768, -32768, re, im, lat, va);
    n_chk++; if (re !== 16'sd0 || im !== -16'sd32768) begin n_fail++; $display("FAIL sat_neg got=(%0d,%0d) exp=(0,-32768)", re, im); end
  endtask

  // Coefficient j maps (dr, di) to (-di, dr).
  task automatic test_backpressure;
    logic [31:0] samp [12];
    logic [31:0] expd [12];
    logic [31:0] prev_data;
    logic        prev_stall;
    int sent, recv, dr, di;
    for (int i = 0; i < 12; i++) begin
      dr = 100 * (i + 1);
      di = -(50 + 3 * i);
      samp[i] = {16'(dr), 16'(di)};
      expd[i] = {16'(-di), 16'(dr)};
    end
    coeff_in = {16'sd0, 16'sd16384};
    sent = 0; recv = 0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 200 && recv < 12; cyc++) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 12);
      in_data   = (sent < 12) ? samp[sent] : '0;
      @(negedge clk);
      if (out_valid && !out_ready) begin
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
      end
      if (prev_stall) begin
        n_chk++; if (out_valid !== 1'b1 || out_data !== prev_data) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, out_data, prev_data); end
      end
      if (out_valid && out_ready) begin
        n_chk++; if (out_data !== expd[recv]) begin n_fail++; $display("FAIL bp_data idx=%0d got=%h exp=%h", recv, out_data, expd[recv]); end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(posedge clk); #1;
    end
    n_chk++; if (recv !== 12 || sent !== 12) begin n_fail++; $display("FAIL bp_count got=%0d/%0d exp=12/12", sent, recv); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra k=%0d got=%b exp=0", k, out_valid); end
      tick;
    end
  endtask

  task automatic test_frame;
    int sent, recv;
    do_reset;
    coeff_in = {16'sd16384, 16'sd0}; out_ready = 1'b1;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 100 && recv < 20; cyc++) begin
      in_valid = (sent < 20);
      in_data  = {16'(sent), 16'(-sent)};
      @(negedge clk);
      if (out_valid && out_ready) begin
        recv++;
        n_chk++; if (out_last !== (recv == 8 || recv == 16)) begin n_fail++; $display("FAIL frame_last xfer=%0d got=%b", recv, out_last); end
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    n_chk++; if (recv !== 20) begin n_fail++; $display("FAIL frame_count got=%0d exp=20", recv); end
    in_valid = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_reset_midframe;
    int sent, recv;
    do_reset;
    coeff_in = {16'sd16384, 16'sd0}; out_ready = 1'b1;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 100 && recv < 5; cyc++) begin
      in_valid = 1'b1;
      in_data  = {16'(sent + 1), 16'sd0};
      @(negedge clk);
      if (out_valid && out_ready) recv++;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick;
    rst = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_flush k=%0d got=%b exp=0", k, out_valid); end
    end
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 100 && recv < 10; cyc++) begin
      in_valid = (sent < 10);
      in_data  = {16'(sent), 16'sd7};
      @(negedge clk);
      if (out_valid && out_ready) begin
        recv++;
        n_chk++; if (out_last !== (recv == 8)) begin n_fail++; $display("FAIL mid_last xfer=%0d got=%b", recv, out_last); end
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    n_chk++; if (recv !== 10) begin n_fail++; $display("FAIL mid_count got=%0d exp=10", recv); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_identity;
    test_rotation;
    test_rounding;
    test_saturation;
    test_backpressure;
    test_frame;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
